// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with req/ack data bus; optional ALIGN_CHECK_EN
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [1:0]  memsizeM,
    input  logic        memsignM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        stallM,
    output logic [31:0] readdataM,
    output logic        buserrM,
    output logic        alignerrM,
    output logic        d_req,
    output logic        d_we,
    output logic [3:0]  d_be,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    input  logic        d_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, nextState;
    logic [7:0]  timeoutCnt;
    logic        timeoutHit;
    logic [1:0]  laneR;
    logic [1:0]  sizeR;
    logic        signR;
    logic        weR;

    logic        isWord, isHalf, misalign;
    logic [1:0]  effLane;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    assign timeoutHit = (timeoutCnt == 8'(TIMEOUT - 1));

    // Held in reset the pipeline must not see a stall; DONE releases it for one cycle.
    assign stallM = rst & memreqM & (state != DONE);

    // Request decode: lane forcing, byte enables and lane-replicated store data.
    always_comb begin
        isWord  = memsizeM[1];
        isHalf  = (memsizeM == 2'b01);
        effLane = isWord ? 2'b00 : (isHalf ? {aluoutM[1], 1'b0} : aluoutM[1:0]);
`ifdef ALIGN_CHECK_EN
        misalign = (isHalf & aluoutM[0]) | (isWord & (aluoutM[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        if (isWord) begin
            reqBe    = 4'b1111;
            reqWdata = writedataM;
        end else if (isHalf) begin
            reqBe    = effLane[1] ? 4'b1100 : 4'b0011;
            reqWdata = {2{writedataM[15:0]}};
        end else begin
            reqBe    = 4'b0001 << effLane;
            reqWdata = {4{writedataM[7:0]}};
        end
    end

    // Load lane extraction and sign/zero extension from the latched request.
    always_comb begin
        case (laneR)
            2'd0:    byteSel = d_rdata[7:0];
            2'd1:    byteSel = d_rdata[15:8];
            2'd2:    byteSel = d_rdata[23:16];
            default: byteSel = d_rdata[31:24];
        endcase
        halfSel = laneR[1] ? d_rdata[31:16] : d_rdata[15:0];
        if (sizeR[1])
            loadData = d_rdata;
        else if (sizeR[0])
            loadData = {{16{signR & halfSel[15]}}, halfSel};
        else
            loadData = {{24{signR & byteSel[7]}}, byteSel};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state: misaligned requests skip the bus entirely; BUSY ends on ack or timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (memreqM) nextState = misalign ? DONE : BUSY;
            BUSY:    if (d_ack || timeoutHit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request latch, bus drive, timeout counting and result/pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeoutCnt <= 8'd0;
            laneR      <= 2'b00;
            sizeR      <= 2'b00;
            signR      <= 1'b0;
            weR        <= 1'b0;
            readdataM  <= 32'd0;
            buserrM    <= 1'b0;
            alignerrM  <= 1'b0;
            d_req      <= 1'b0;
            d_we       <= 1'b0;
            d_be       <= 4'd0;
            d_addr     <= 32'd0;
            d_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (memreqM) begin
                        laneR      <= effLane;
                        sizeR      <= memsizeM;
                        signR      <= memsignM;
                        weR        <= memwriteM;
                        timeoutCnt <= 8'd0;
                        if (misalign) begin
                            alignerrM <= 1'b1;
                            readdataM <= 32'd0;
                        end else begin
                            d_req   <= 1'b1;
                            d_we    <= memwriteM;
                            d_be    <= reqBe;
                            d_addr  <= {aluoutM[31:2], 2'b00};
                            d_wdata <= reqWdata;
                        end
                    end
                end
                BUSY: begin
                    if (d_ack) begin
                        d_req <= 1'b0;
                        if (!weR)
                            readdataM <= loadData;
                    end else if (timeoutHit) begin
                        d_req     <= 1'b0;
                        buserrM   <= 1'b1;
                        readdataM <= 32'd0;
                    end else begin
                        timeoutCnt <= timeoutCnt + 8'd1;
                    end
                end
                default: begin
                    buserrM   <= 1'b0;
                    alignerrM <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memreqM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [1:0]  memsizeM = 2'b00;
    logic        memsignM = 1'b0;
    logic [31:0] aluoutM = 32'd0;
    logic [31:0] writedataM = 32'd0;
    logic        stallM;
    logic [31:0] readdataM;
    logic        buserrM;
    logic        alignerrM;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata = 32'd0;
    logic        d_ack = 1'b0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .memreqM(memreqM), .memwriteM(memwriteM),
        .memsizeM(memsizeM), .memsignM(memsignM), .aluoutM(aluoutM),
        .writedataM(writedataM), .stallM(stallM), .readdataM(readdataM),
        .buserrM(buserrM), .alignerrM(alignerrM), .d_req(d_req), .d_we(d_we),
        .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rd;
        int          stalls;
        logic        berr;
        logic        aerr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] lastRead = 32'd0;

    logic        seenReq, seenWe;
    logic [3:0]  seenBe;
    logic [31:0] seenAddr, seenWdata;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sign,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*addr[1:0] +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        if (size[1]) return rdata;
        if (size == 2'b01) return sign ? {{16{h[15]}}, h} : {16'd0, h};
        return sign ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

    // ackAfter = BUSY cycle (1-based) on which d_ack is raised; 0 = never ack
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic sign, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ackAfter, input bit earlyAck);
        exp_t e;
        bit   mis;
        bit   done;
        int   stalls;
        int   busy;
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`endif
        if (mis)
            e = '{32'd0, 1, 1'b0, 1'b1};
        else if (ackAfter == 0)
            e = '{32'd0, 1 + TO, 1'b1, 1'b0};
        else
            e = '{we ? lastRead : modelLoad(size, sign, addr, rdata), 1 + ackAfter, 1'b0, 1'b0};
        lastRead = e.rd;
        sb.push_back(e);

        @(negedge clk);
        memreqM = 1'b1; memwriteM = we; memsizeM = size; memsignM = sign;
        aluoutM = addr; writedataM = wd; d_ack = 1'b0;
        stalls = 0; busy = 0; done = 1'b0; seenReq = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (!stallM) begin
                done = 1'b1;
                d_ack = 1'b0;
            end else begin
                stalls++;
                if (d_req) begin
                    busy++;
                    if (!seenReq) begin
                        seenReq = 1'b1; seenWe = d_we; seenBe = d_be;
                        seenAddr = d_addr; seenWdata = d_wdata;
                    end
                    d_rdata = rdata;
                    d_ack = (busy == ackAfter);
                end else begin
                    d_rdata = 32'hBAD0_0BAD;
                    d_ack = earlyAck;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            checkVal({tag, "-done-wait"}, 32'd0, 32'd1);
            memreqM = 1'b0; d_ack = 1'b0;
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checkVal({tag, "-readdata"}, readdataM, e.rd);
        checkVal({tag, "-stalls"}, stalls, e.stalls);
        checkVal({tag, "-buserr"}, {31'd0, buserrM}, {31'd0, e.berr});
        checkVal({tag, "-alignerr"}, {31'd0, alignerrM}, {31'd0, e.aerr});
        memreqM = 1'b0;
        @(negedge clk);
        #1;
        checkVal({tag, "-pulse-end"}, {30'd0, buserrM, alignerrM}, 32'd0);
        checkVal({tag, "-req-idle"}, {31'd0, d_req}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        checkVal("rst-stall", {31'd0, stallM}, 32'd0);
        checkVal("rst-req", {31'd0, d_req}, 32'd0);
        checkVal("rst-readdata", readdataM, 32'd0);
        checkVal("rst-be", {28'd0, d_be}, 32'd0);
        checkVal("rst-errs", {30'd0, buserrM, alignerrM}, 32'd0);
        rst = 1'b1;

        access("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 1, 1'b0);
        checkVal("lw-addr", seenAddr, 32'h100);
        checkVal("lw-be", {28'd0, seenBe}, 32'hF);
        access("lb", 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80FFFFFF, 1, 1'b0);
        access("lbu", 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80FFFFFF, 1, 1'b0);
        access("lh", 1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 32'h80011234, 2, 1'b0);
        access("lhu", 1'b0, 2'b01, 1'b0, 32'h100, 32'd0, 32'h80019234, 1, 1'b0);

        access("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 1, 1'b0);
        checkVal("sh-we", {31'd0, seenWe}, 32'd1);
        checkVal("sh-be", {28'd0, seenBe}, 32'hC);
        checkVal("sh-wdata", seenWdata, 32'hABCDABCD);
        checkVal("sh-addr", seenAddr, 32'h100);
        access("sb", 1'b1, 2'b00, 1'b0, 32'h201, 32'h00000055, 32'h0, 3, 1'b0);
        checkVal("sb-be", {28'd0, seenBe}, 32'h2);
        checkVal("sb-wdata", seenWdata, 32'h55555555);

        access("early-ack", 1'b0, 2'b11, 1'b0, 32'h300, 32'd0, 32'h0BADF00D, 2, 1'b1);
        access("timeout", 1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 32'h12345678, 0, 1'b0);

        access("lw-mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 32'hCAFEF00D, 1, 1'b0);
`ifdef ALIGN_CHECK_EN
        checkVal("lw-mis-noreq", {31'd0, seenReq}, 32'd0);
`else
        checkVal("lw-mis-addr", seenAddr, 32'h100);
        checkVal("lw-mis-be", {28'd0, seenBe}, 32'hF);
`endif

        @(negedge clk);
        memreqM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; aluoutM = 32'h500;
        @(negedge clk);
        #1;
        checkVal("rstbusy-req-before", {31'd0, d_req}, 32'd1);
        rst = 1'b0;
        #1;
        checkVal("rstbusy-req", {31'd0, d_req}, 32'd0);
        checkVal("rstbusy-stall", {31'd0, stallM}, 32'd0);
        checkVal("rstbusy-readdata", readdataM, 32'd0);
        @(negedge clk);
        memreqM = 1'b0; rst = 1'b1; lastRead = 32'd0;
        @(negedge clk);
        #1;
        checkVal("rstrel-req", {31'd0, d_req}, 32'd0);
        checkVal("rstrel-stall", {31'd0, stallM}, 32'd0);
        access("post-rst-lw", 1'b0, 2'b10, 1'b0, 32'h600, 32'd0, 32'h13579BDF, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
